// File: rtl/credit_fifo_lbdr_in.sv
// Credit-based FWFT input buffer feeding LBDR routing and its parity checker.
// Define FIFO_ERR_FLAG_EN to add sticky overflow_err/underflow_err outputs.
module credit_fifo_lbdr_in #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  valid_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  credit_out
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow_err,
  output logic                  underflow_err
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic                  grant;
  logic                  rd;
  logic                  wr;

  // Extra wrap bit distinguishes full from empty when indices match.
  assign empty_out = (wr_ptr == rd_ptr);
  assign full_out  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                     (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

  assign grant = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign rd    = grant & ~empty_out;
  assign wr    = valid_in & ~full_out;

  assign Data_out = mem[rd_ptr[PTR_WIDTH-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      credit_out <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      credit_out <= rd;
      if (wr) begin
        mem[wr_ptr[PTR_WIDTH-1:0]] <= RX;
        wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
      end
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (valid_in && full_out) begin
        overflow_err <= 1'b1;
      end
      if (grant && empty_out) begin
        underflow_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_credit_fifo_lbdr_in.sv
// Directed table-driven bench for credit_fifo_lbdr_in.
// Covers fill/drain, drop-on-full, FWFT head, wrap, empty+write, async reset.
module tb_credit_fifo_lbdr_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RX;
  logic        valid_in;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty_out, full_out, credit_out;
`ifdef FIFO_ERR_FLAG_EN
  logic        overflow_err, underflow_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  credit_fifo_lbdr_in dut (
    .clk(clk),
    .reset(reset),
    .RX(RX),
    .valid_in(valid_in),
    .read_en_N(read_en_N),
    .read_en_E(read_en_E),
    .read_en_W(read_en_W),
    .read_en_S(read_en_S),
    .read_en_L(read_en_L),
    .Data_out(Data_out),
    .empty_out(empty_out),
    .full_out(full_out),
    .credit_out(credit_out)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
`endif
  );

  // g = {N,E,W,S,L}; expected values hold just after the applied edge
  typedef struct {
    logic        v;
    logic [31:0] rx;
    logic [4:0]  g;
    logic        e_empty;
    logic        e_full;
    logic        e_credit;
    logic [31:0] e_data;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [31:0] rx,
                     input logic [4:0] g, input logic ee,
                     input logic ef, input logic ec,
                     input logic [31:0] ed, input logic cd);
    vec_t t;
    t.v = v; t.rx = rx; t.g = g;
    t.e_empty = ee; t.e_full = ef; t.e_credit = ec;
    t.e_data = ed; t.chk_data = cd;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] rx,
                       input logic [4:0] g);
    valid_in = v;
    RX = rx;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = g;
  endtask

  task automatic step(input logic v, input logic [31:0] rx,
                      input logic [4:0] g);
    @(negedge clk);
    drive(v, rx, g);
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] GN = 5'b10000;
  localparam logic [4:0] GE = 5'b01000;
  localparam logic [4:0] GW = 5'b00100;
  localparam logic [4:0] GS = 5'b00010;
  localparam logic [4:0] GL = 5'b00001;

  initial begin
    // basic fill / FWFT head
    add(0, 0, 0, 1, 0, 0, 32'h0, 1);
    add(1, 32'h3, 0, 0, 0, 0, 32'h3, 1);
    add(1, 32'h5, 0, 0, 0, 0, 32'h3, 1);
    add(0, 0, GE, 0, 0, 1, 32'h5, 1);
    add(0, 0, GE, 1, 0, 1, 32'h0, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0, 0);
    // fill to full, drop on full, full+valid+grant pops and drops
    add(1, 32'h11, 0, 0, 0, 0, 32'h11, 1);
    add(1, 32'h22, 0, 0, 0, 0, 32'h11, 1);
    add(1, 32'h33, 0, 0, 0, 0, 32'h11, 1);
    add(1, 32'h44, 0, 0, 1, 0, 32'h11, 1);
    add(1, 32'h55, 0, 0, 1, 0, 32'h11, 1);
    add(1, 32'h66, GN, 0, 0, 1, 32'h22, 1);
    add(0, 0, GW, 0, 0, 1, 32'h33, 1);
    add(0, 0, GS, 0, 0, 1, 32'h44, 1);
    add(0, 0, GL, 1, 0, 1, 32'h0, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0, 0);
    // empty + write + grants: write wins, no credit
    add(1, 32'hA5A5A5A4, GL | GN, 0, 0, 0, 32'hA5A5A5A4, 1);
    add(1, 32'hB0, 0, 0, 0, 0, 32'hA5A5A5A4, 1);
    // steady two-flit streaming across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) add(1, 32'hC0, GE, 0, 0, 1, 32'hB0, 1);
      else add(1, 32'hC0 + k - 1, GE, 0, 0, 1, 32'hC0 + k - 2, 1);
    end
    add(0, 0, 0, 0, 0, 0, 32'hC8, 1);
    add(0, 0, GE, 0, 0, 1, 32'hC9, 1);
    add(0, 0, 0, 0, 0, 0, 32'hC9, 1);

    drive(0, 0, 0);
    reset = 1'b1;
    #12;
    chk("rst_empty", 32'(empty_out), 32'h1);
    chk("rst_full", 32'(full_out), 32'h0);
    chk("rst_credit", 32'(credit_out), 32'h0);
    chk("rst_data", Data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].rx, vecs[i].g);
      chk($sformatf("v%0d_empty", i), 32'(empty_out), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i), 32'(full_out), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_credit", i), 32'(credit_out),
          32'(vecs[i].e_credit));
      if (vecs[i].chk_data)
        chk($sformatf("v%0d_data", i), Data_out, vecs[i].e_data);
    end

    // mid-stream async reset with a pop pending
    step(1, 32'h71, 0);
    step(1, 32'h72, 0);
    chk("pre_rst_empty", 32'(empty_out), 32'h0);
    chk("pre_rst_data", Data_out, 32'hC9);
`ifdef FIFO_ERR_FLAG_EN
    chk("ovf_sticky", 32'(overflow_err), 32'h1);
    chk("udf_sticky", 32'(underflow_err), 32'h1);
`endif
    @(negedge clk);
    drive(0, 0, GN);
    #2;
    reset = 1'b1;
    #1;
    chk("async_empty", 32'(empty_out), 32'h1);
    chk("async_full", 32'(full_out), 32'h0);
    chk("async_data", Data_out, 32'h0);
    chk("async_credit", 32'(credit_out), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_credit", 32'(credit_out), 32'h0);
`ifdef FIFO_ERR_FLAG_EN
    chk("ovf_cleared", 32'(overflow_err), 32'h0);
    chk("udf_cleared", 32'(underflow_err), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0);
    step(1, 32'h7, 0);
    chk("post_rst_data", Data_out, 32'h7);
    chk("post_rst_empty", 32'(empty_out), 32'h0);
    chk("post_rst_credit", 32'(credit_out), 32'h0);
    step(0, 0, GS);
    chk("post_rst_pop_credit", 32'(credit_out), 32'h1);
    chk("post_rst_pop_empty", 32'(empty_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_fifo_lbdr_in.md
Name: credit_fifo_lbdr_in

Overview:
Credit-based input buffer for one router input port. It sits directly upstream of the LBDR routing logic and the LBDR parity checker. It stores incoming flits and presents the head flit on Data_out together with empty_out, in first-word-fall-through mode. It returns one credit upstream for every flit consumed by the downstream allocator.

Parameters:
DATA_WIDTH, 32, flit width in bits; bit 0 carries the flit's even-parity bit and passes through untouched.
DEPTH, 4, number of flit slots; must be a power of 2 and at least 2.
PTR_WIDTH, 2, log2(DEPTH); width of the slot index.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
RX  in  DATA_WIDTH  incoming flit from the upstream link.
valid_in  in  1  RX holds a valid flit this cycle.
read_en_N  in  1  allocator grant: north output pops the head flit.
read_en_E  in  1  allocator grant: east output pops the head flit.
read_en_W  in  1  allocator grant: west output pops the head flit.
read_en_S  in  1  allocator grant: south output pops the head flit.
read_en_L  in  1  allocator grant: local output pops the head flit.
Data_out  out  DATA_WIDTH  head flit (FWFT); feeds the LBDR unit and the parity checker RX input.
empty_out  out  1  FIFO holds no flits; feeds the parity checker empty input.
full_out  out  1  FIFO holds DEPTH flits.
credit_out  out  1  one-cycle pulse returning one credit to upstream.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are PTR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty when wr_ptr == rd_ptr.
  - full when the index bits are equal and the wrap bits differ.
- empty_out and full_out are combinational from the registered pointers.
- Data_out = mem[rd_ptr index], combinational; no read latency.
  - When empty, Data_out shows the stale slot content; consumers must qualify it with empty_out.
- rd = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty_out.
  - Several grants asserted in one cycle count as a single pop.
- wr = valid_in & ~full_out.
  - Full is evaluated at the start of the cycle. A write while full is dropped even if a read happens in the same cycle.
- On wr: mem[wr_ptr index] <= RX; wr_ptr increments mod 2^(PTR_WIDTH+1).
- On rd: rd_ptr increments mod 2^(PTR_WIDTH+1).
- Simultaneous rd and wr (neither full nor empty): both happen; occupancy is unchanged.
- Empty plus valid_in plus grant in the same cycle: the read is ignored and the write is accepted. empty_out falls on the next cycle.
- Full plus valid_in plus grant in the same cycle: the read happens and the write is dropped. full_out falls on the next cycle.
- credit_out <= rd (registered). It pulses high for exactly one cycle, one cycle after each successful pop.
  - Back-to-back pops give a continuous high, one credit per cycle.
- Pointer wrap: after 2^(PTR_WIDTH+1) writes the pointers return to 0 with no glitch on full or empty.
- Reset (asynchronous, takes effect immediately, also mid-transfer):
  - wr_ptr = 0, rd_ptr = 0, all mem slots = 0.
  - credit_out = 0, empty_out = 1, full_out = 0, Data_out = 0.
  - Flits in flight are discarded; no credits are returned for them.

Optional Feature:
Macro FIFO_ERR_FLAG_EN.
- Defined: adds outputs overflow_err (1) and underflow_err (1).
  - overflow_err sets when valid_in & full_out.
  - underflow_err sets when any read_en is asserted while empty_out is high.
  - Both are sticky until reset and reset to 0.
- Not defined: these ports do not exist. The same conditions are silently ignored, as described in Behaviour.

Test Plan:
- Reset, then idle -> empty_out=1, full_out=0, credit_out=0, Data_out=0x00000000.
- Write 0x00000003, then 0x00000005, with no reads -> cycle after first write: empty_out=0, Data_out=0x00000003. Head stays 0x00000003 after the second write.
- Write 4 flits 0x11..0x44, then present a 5th (0x55) with no reads -> full_out=1 after the 4th write. 0x55 is dropped. Popping 4 times yields 0x11, 0x22, 0x33, 0x44, and credit_out pulses 4 times, each one cycle after its pop.
- Hold FIFO at 2 flits; assert valid_in and read_en_E together for 10 cycles with incrementing data -> occupancy stays 2, credit_out high for 10 consecutive cycles, pointers wrap with no spurious empty or full.
- Empty FIFO; assert read_en_L and read_en_N together with valid_in=1, RX=0xA5A5A5A4 -> no pop, credit_out stays 0. Next cycle Data_out=0xA5A5A5A4 and empty_out=0. With FIFO_ERR_FLAG_EN defined, underflow_err=1.
- 3 flits stored; assert reset for 1 cycle mid-stream -> empty_out=1 immediately (asynchronously), no credit_out pulse, and the next write of 0x7 appears on Data_out one cycle later.
